producto_bcd: RTL

Sequential binary-to-BCD converter placed directly downstream of the shift-add multiplier system. It consumes the multiplier's Producto and Ready outputs and captures each new product when Ready rises. It converts the product to packed BCD digits with the iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock, for the display/output stage.

---
 rtl/producto_bcd.sv | 103 ++++++++++
 1 files changed

// File: rtl/producto_bcd.sv
// ============================================================================
//  producto_bcd : converts the multiplier product to packed BCD by
//                 double-dabble, one bit per clock. Rev 1.0
// ============================================================================
`default_nettype none

module producto_bcd #(
   parameter int WIDTH  = 17,
   parameter int DIGITS = 6,
   parameter int CW     = 5
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Ready_in,
   input  logic [WIDTH-1:0]      Producto,
   output logic [4*DIGITS-1:0]   BCD,
   output logic                  Busy,
   output logic                  Done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic                    ready_q;
   logic                    start;
   logic                    last_shift;
   logic [WIDTH-1:0]        bin_reg;
   logic [4*DIGITS-1:0]     scratch;
   logic [4*DIGITS-1:0]     corrected;
   logic [4*DIGITS+WIDTH-1:0] joined;
   logic [CW-1:0]           counter;

   // ready_q resets high so a Ready_in already high at reset release is not an edge
   assign start      = Ready_in & ~ready_q;
   assign last_shift = (counter == CW'(1));

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign corrected[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ?
                                   (scratch[4*i +: 4] + 4'd3) :
                                    scratch[4*i +: 4];
   end

   assign joined = {corrected, bin_reg} << 1;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      Busy      = 1'b0;
      Done      = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nxt = S_SHIFT;
         S_SHIFT: begin
            Busy = 1'b1;
            if (last_shift) state_nxt = S_DONE;
         end
         S_DONE: begin
            Done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         ready_q <= 1'b1;
         bin_reg <= '0;
         scratch <= '0;
         counter <= '0;
         BCD     <= '0;
      end else begin
         ready_q <= Ready_in;
         case (state)
            S_IDLE: begin
               if (start) begin
                  bin_reg <= Producto;
                  scratch <= '0;
                  counter <= CW'(WIDTH);
               end
            end
            S_SHIFT: begin
               scratch <= joined[4*DIGITS+WIDTH-1 : WIDTH];
               bin_reg <= joined[WIDTH-1:0];
               counter <= counter - CW'(1);
               if (last_shift) BCD <= joined[4*DIGITS+WIDTH-1 : WIDTH];
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
